// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants, decoder state encoding and byte classification.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_ERR0    = 8'h00;
  localparam logic [7:0] PS2_ERR1    = 8'hFF;
  localparam logic [7:0] PS2_RESEND  = 8'hFE;
  localparam logic [7:0] PS2_BATFAIL = 8'hFC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  // Keyboard error / resend codes never form part of a key sequence.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_RESEND) || (b == PS2_BATFAIL);
  endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and pulses
// expire in the cycle the count sits at TIMEOUT_CYCLES-1 without a clear.
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear dominates; the terminal count wraps to zero as it raises expire.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0 prefixes into single key events,
// flags error bytes and stalled sequences, and keeps a 3-byte raw history.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        i_sclr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_key_valid,
  output logic [7:0]  o_key_code,
  output logic        o_key_ext,
  output logic        o_key_break,
  output logic        o_err,
  output logic        o_busy,
  output logic [23:0] o_history
);

  ps2_state_e  state_q, state_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  key_code_q, key_code_d;
  logic        key_ext_q, key_ext_d;
  logic        key_break_q, key_break_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [23:0] history_q, history_d;
  logic        expire;

  // The watchdog only runs while a prefix is pending; any byte restarts it.
  ps2_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (i_sclr),
    .clr   (i_valid || (state_q == ST_IDLE)),
    .en    (state_q != ST_IDLE),
    .expire(expire)
  );

  // Sequence parser; a received byte always wins over a same-cycle timeout.
  always_comb begin
    state_d     = state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    err_d       = 1'b0;
    history_d   = history_q;
    if (i_valid) begin
      history_d = {history_q[15:0], i_data};
      state_d   = ST_IDLE;
      case (state_q)
        ST_IDLE: begin
          if (i_data == PS2_EXT)      state_d = ST_EXT;
          else if (i_data == PS2_BRK) state_d = ST_BRK;
          else if (is_err_byte(i_data)) err_d = 1'b1;
          else begin
            key_valid_d = 1'b1;
            key_code_d  = i_data;
            key_ext_d   = 1'b0;
            key_break_d = 1'b0;
          end
        end
        ST_EXT: begin
          if (i_data == PS2_BRK)      state_d = ST_EXT_BRK;
          else if (i_data == PS2_EXT) state_d = ST_EXT;
          else if (is_err_byte(i_data)) err_d = 1'b1;
          else begin
            key_valid_d = 1'b1;
            key_code_d  = i_data;
            key_ext_d   = 1'b1;
            key_break_d = 1'b0;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          if ((i_data == PS2_EXT) || (i_data == PS2_BRK) || is_err_byte(i_data)) begin
            err_d = 1'b1;
          end else begin
            key_valid_d = 1'b1;
            key_code_d  = i_data;
            key_ext_d   = (state_q == ST_EXT_BRK);
            key_break_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expire) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      history_q   <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      history_q   <= history_d;
    end
  end

  assign o_key_valid = key_valid_q;
  assign o_key_code  = key_code_q;
  assign o_key_ext   = key_ext_q;
  assign o_key_break = key_break_q;
  assign o_err       = err_q;
  assign o_busy      = busy_q;
  assign o_history   = history_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a back-to-back byte table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_ps2_scancode_decoder;

  logic        clk = 1'b0;
  logic        i_sclr;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_key_valid;
  logic [7:0]  o_key_code;
  logic        o_key_ext;
  logic        o_key_break;
  logic        o_err;
  logic        o_busy;
  logic [23:0] o_history;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        kv;
    logic        err;
    logic        busy;
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [23:0] hist;
  } vec_t;

  vec_t vecs[$];

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .i_sclr     (i_sclr),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_key_valid(o_key_valid),
    .o_key_code (o_key_code),
    .o_key_ext  (o_key_ext),
    .o_key_break(o_key_break),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_history  (o_history)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {27'd0, o_key_valid, o_err, o_busy, o_key_code, o_key_ext, o_key_break, o_history};
  endfunction

  task automatic add(input logic [7:0] d, input logic kv, input logic err, input logic busy,
                     input logic [7:0] code, input logic ext, input logic brk, input logic [23:0] hist);
    vec_t v;
    v.data = d; v.kv = kv; v.err = err; v.busy = busy;
    v.code = code; v.ext = ext; v.brk = brk; v.hist = hist;
    vecs.push_back(v);
  endtask

  task automatic send(input logic [7:0] d);
    i_valid = 1'b1;
    i_data  = d;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  initial begin
    logic [63:0] exp;
    logic        quiet;

    //   data   kv err busy code  ext brk history
    add(8'h1C, 1, 0, 0, 8'h1C, 0, 0, 24'h00001C);
    add(8'hF0, 0, 0, 1, 8'h1C, 0, 0, 24'h001CF0);
    add(8'h1C, 1, 0, 0, 8'h1C, 0, 1, 24'h1CF01C);
    add(8'hE0, 0, 0, 1, 8'h1C, 0, 1, 24'hF01CE0);
    add(8'hF0, 0, 0, 1, 8'h1C, 0, 1, 24'h1CE0F0);
    add(8'h75, 1, 0, 0, 8'h75, 1, 1, 24'hE0F075);
    add(8'hF0, 0, 0, 1, 8'h75, 1, 1, 24'hF075F0);
    add(8'hF0, 0, 1, 0, 8'h75, 1, 1, 24'h75F0F0);
    add(8'h29, 1, 0, 0, 8'h29, 0, 0, 24'hF0F029);
    add(8'hFE, 0, 1, 0, 8'h29, 0, 0, 24'hF029FE);
    add(8'hE0, 0, 0, 1, 8'h29, 0, 0, 24'h29FEE0);
    add(8'hE0, 0, 0, 1, 8'h29, 0, 0, 24'hFEE0E0);
    add(8'h6B, 1, 0, 0, 8'h6B, 1, 0, 24'hE0E06B);
    add(8'hE0, 0, 0, 1, 8'h6B, 1, 0, 24'hE06BE0);
    add(8'hFF, 0, 1, 0, 8'h6B, 1, 0, 24'h6BE0FF);
    add(8'hF0, 0, 0, 1, 8'h6B, 1, 0, 24'hE0FFF0);
    add(8'hE0, 0, 1, 0, 8'h6B, 1, 0, 24'hFFF0E0);
    add(8'hE0, 0, 0, 1, 8'h6B, 1, 0, 24'hF0E0E0);
    add(8'hF0, 0, 0, 1, 8'h6B, 1, 0, 24'hE0E0F0);
    add(8'hE0, 0, 1, 0, 8'h6B, 1, 0, 24'hE0F0E0);
    add(8'hAA, 1, 0, 0, 8'hAA, 0, 0, 24'hF0E0AA);
    add(8'h00, 0, 1, 0, 8'hAA, 0, 0, 24'hE0AA00);
    add(8'hE1, 1, 0, 0, 8'hE1, 0, 0, 24'hAA00E1);
    add(8'hF0, 0, 0, 1, 8'hE1, 0, 0, 24'h00E1F0);
    add(8'hFC, 0, 1, 0, 8'hE1, 0, 0, 24'hE1F0FC);

    // Reset state
    i_sclr  = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", obs(), 64'd0);
    i_sclr = 1'b0;
    @(posedge clk); #1;

    // Back-to-back byte table
    for (int i = 0; i < vecs.size(); i++) begin
      i_valid = 1'b1;
      i_data  = vecs[i].data;
      @(posedge clk); #1;
      exp = {27'd0, vecs[i].kv, vecs[i].err, vecs[i].busy, vecs[i].code,
             vecs[i].ext, vecs[i].brk, vecs[i].hist};
      check($sformatf("vec%0d_%h", i, vecs[i].data), obs(), exp);
    end
    i_valid = 1'b0;
    @(posedge clk); #1;
    check("pulses_drop", {o_key_valid, o_err, o_busy}, 3'b000);

    // Timeout: E0 then silence, o_err on the 8th edge after E0 was taken
    send(8'hE0);
    check("to_busy_after_e0", o_busy, 1'b1);
    quiet = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      if (o_err !== 1'b0 || o_busy !== 1'b1 || o_key_valid !== 1'b0) quiet = 1'b0;
    end
    check("to_quiet_before_expiry", quiet, 1'b1);
    @(posedge clk); #1;
    check("to_err_busy_kv", {o_err, o_busy, o_key_valid}, 3'b100);
    @(posedge clk); #1;
    check("to_err_one_cycle", {o_err, o_busy}, 2'b00);

    // Byte arriving in the terminal timeout cycle wins
    send(8'hE0);
    repeat (7) @(posedge clk);
    #1;
    send(8'h5A);
    check("term_event", {o_key_valid, o_err, o_busy, o_key_code, o_key_ext, o_key_break},
          {1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0});
    repeat (9) @(posedge clk);
    #1;
    check("term_no_late_err", {o_err, o_busy}, 2'b00);

    // Asynchronous reset mid-sequence
    send(8'hE0);
    check("ar_busy_before", o_busy, 1'b1);
    #3;
    i_sclr = 1'b1;
    #1;
    check("ar_immediate", {o_busy, o_err, o_key_valid, o_history}, {3'b000, 24'h000000});
    @(posedge clk); #1;
    check("ar_held", {o_busy, o_err, o_history}, {2'b00, 24'h000000});
    i_sclr = 1'b0;
    @(posedge clk); #1;
    send(8'hF0);
    check("ar_f0_busy", {o_busy, o_err, o_history}, {2'b10, 24'h0000F0});
    send(8'h12);
    check("ar_event", {o_key_valid, o_err, o_busy, o_key_code, o_key_ext, o_key_break, o_history},
          {1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, 24'h00F012});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
